softex_tail_ctrl: RTL

- Elastic single-register stage between the output FIFO of the softmax datapath and the output streamer (sink side).
- Counts vector beats against a programmed element count per job.
- On the final, possibly partial beat: zeroes the unused lanes and clears their strobes.
- Stops accepting beats once the job is complete, then raises a done pulse for the controller.

---
 rtl/softex_tail_ctrl_pkg.sv | 18 +
 rtl/softex_tail_ctrl_if.sv | 19 +
 rtl/softex_lane_mask.sv | 24 ++
 rtl/softex_tail_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/softex_tail_ctrl_pkg.sv
// Shared types for the softmax output tail controller.
package softex_tail_ctrl_pkg;

  localparam int unsigned TAIL_LEN_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } tail_ctrl_state_e;

  // Lets the main controller drive a job request as a single bundle.
  typedef struct packed {
    logic                      start;
    logic [TAIL_LEN_WIDTH-1:0] len;
  } tail_ctrl_t;

endpackage

// File: rtl/softex_tail_ctrl_if.sv
// Valid/ready stream carrying data plus byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 128
);
  import softex_tail_ctrl_pkg::*;

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input  ready);
  modport sink   (input  valid, input  data, input  strb, output ready);
  modport master (output valid, output data, output strb, input  ready);
  modport slave  (input  valid, input  data, input  strb, output ready);

endinterface

// File: rtl/softex_lane_mask.sv
// Turns the remaining element count into per-lane and per-byte enables.
module softex_lane_mask
  import softex_tail_ctrl_pkg::*;
#(
  parameter int unsigned N_LANES   = 8,
  parameter int unsigned BPL       = 2,
  parameter int unsigned LEN_WIDTH = 32
) (
  input  logic [LEN_WIDTH-1:0]     remaining,
  output logic [N_LANES-1:0]       lane_mask,
  output logic [N_LANES*BPL-1:0]   byte_mask
);

  // Lane i carries a valid element only while more than i elements remain.
  always_comb begin
    lane_mask = '0;
    byte_mask = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_mask[i]             = (remaining > LEN_WIDTH'(i));
      byte_mask[i*BPL +: BPL]  = {BPL{remaining > LEN_WIDTH'(i)}};
    end
  end

endmodule

// File: rtl/softex_tail_ctrl.sv
// Output tail stage: counts beats of a job, masks the partial last beat,
// then stops accepting and signals completion.
module softex_tail_ctrl
  import softex_tail_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ELEM_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  output logic                   busy_o,
  output logic                   done_o,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o
);

  localparam int unsigned N_LANES = DATA_WIDTH / ELEM_WIDTH;
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned BPL     = ELEM_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] LEN_N = LEN_WIDTH'(N_LANES);

  tail_ctrl_state_e      state_q, state_d;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [STRB_W-1:0]     out_strb_q;
  logic                  done_q, done_d;
  logic                  push_ready;
  logic                  push_hs;
  logic                  pop_hs;
  logic                  last_beat;
  logic [N_LANES-1:0]    lane_mask;
  logic [STRB_W-1:0]     byte_mask;
  logic [DATA_WIDTH-1:0] masked_data;

  softex_lane_mask #(
    .N_LANES   (N_LANES),
    .BPL       (BPL),
    .LEN_WIDTH (LEN_WIDTH)
  ) i_lane_mask (
    .remaining (remaining_q),
    .lane_mask (lane_mask),
    .byte_mask (byte_mask)
  );

  assign pop_hs    = out_valid_q & pop_o.ready;
  assign push_hs   = push_i.valid & push_ready;
  assign last_beat = (remaining_q <= LEN_N);

  // Zero the data of lanes that lie beyond the end of the job.
  always_comb begin
    masked_data = '0;
    for (int i = 0; i < N_LANES; i++) begin
      masked_data[i*ELEM_WIDTH +: ELEM_WIDTH] =
        push_i.data[i*ELEM_WIDTH +: ELEM_WIDTH] & {ELEM_WIDTH{lane_mask[i]}};
    end
  end

  // Next-state, input-ready and done decisions; a clear overrides all of them.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    push_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = RUN;
          else             done_d  = 1'b1;
        end
      end
      RUN: begin
        push_ready = !out_valid_q || pop_o.ready;
        if (push_i.valid && push_ready && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid_q || pop_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      push_ready = 1'b0;
    end
  end

  // State register and the registered completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Elements still owed by the job; saturates at zero on the final beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining_q <= '0;
    end else if (clear_i) begin
      remaining_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      remaining_q <= len_i;
    end else if (push_hs) begin
      remaining_q <= last_beat ? '0 : remaining_q - LEN_N;
    end
  end

  // Single elastic output register; a push in the same cycle as a pop replaces it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else if (clear_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
    end else if (push_hs) begin
      out_valid_q <= 1'b1;
      out_data_q  <= masked_data;
      out_strb_q  <= push_i.strb & byte_mask;
    end else if (pop_hs) begin
      out_valid_q <= 1'b0;
    end
  end

  assign push_i.ready = push_ready;
  assign pop_o.valid  = out_valid_q;
  assign pop_o.data   = out_data_q;
  assign pop_o.strb   = out_strb_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule
